// File: rtl/kernel_onchip_mem_burst_adapter.sv
// Avalon-MM burst slave that feeds the kernel on-chip RAM one word per cycle; reads return 1 cycle after issue.
// Backpressure: s_waitrequest holds for the remaining beats of a read burst; write bursts stall on s_write low.
module kernel_onchip_mem_burst_adapter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          s_address,
    input  logic [$clog2(MAX_BURST):0] s_burstcount,
    input  logic                       s_read,
    input  logic                       s_write,
    input  logic [DATA_W-1:0]          s_writedata,
    input  logic [DATA_W/8-1:0]        s_byteenable,
    output logic                       s_waitrequest,
    output logic [DATA_W-1:0]          s_readdata,
    output logic                       s_readdatavalid,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W/8-1:0]        mem_byteenable,
    output logic                       mem_chipselect,
    output logic                       mem_write,
    output logic [DATA_W-1:0]          mem_writedata,
    output logic                       mem_clken,
    input  logic [DATA_W-1:0]          mem_readdata
);

    localparam int BC_W = $clog2(MAX_BURST) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WBURST = 2'd1;
    localparam logic [1:0] RBURST = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [BC_W-1:0]   beats_left;
    logic [BC_W-1:0]   n_eff;

    assign n_eff         = (s_burstcount == '0) ? BC_W'(1) : s_burstcount;
    assign s_waitrequest = (state == RBURST) | reset;
    assign s_readdata    = mem_readdata;
    assign mem_writedata = s_writedata;
    assign mem_clken     = 1'b1;

    // Beat 0 of every command reaches the RAM in the acceptance cycle; later beats come from addr_cnt.
    always_comb begin
        mem_address    = addr_cnt;
        mem_byteenable = '1;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (s_write) begin
                        mem_address    = s_address;
                        mem_byteenable = s_byteenable;
                        mem_chipselect = 1'b1;
                        mem_write      = 1'b1;
                    end else if (s_read) begin
                        mem_address    = s_address;
                        mem_chipselect = 1'b1;
                    end
                end
                WBURST: begin
                    if (s_write) begin
                        mem_byteenable = s_byteenable;
                        mem_chipselect = 1'b1;
                        mem_write      = 1'b1;
                    end
                end
                RBURST: begin
                    mem_chipselect = 1'b1;
                end
                default: begin
                    mem_chipselect = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            addr_cnt        <= '0;
            beats_left      <= '0;
            s_readdatavalid <= 1'b0;
        end else begin
            s_readdatavalid <= mem_chipselect & ~mem_write;
            case (state)
                IDLE: begin
                    if ((s_write || s_read) && n_eff > BC_W'(1)) begin
                        addr_cnt   <= s_address + ADDR_W'(1);
                        beats_left <= n_eff - BC_W'(1);
                        state      <= s_write ? WBURST : RBURST;
                    end
                end
                WBURST: begin
                    if (s_write) begin
                        addr_cnt   <= addr_cnt + ADDR_W'(1);
                        beats_left <= beats_left - BC_W'(1);
                        if (beats_left == BC_W'(1)) state <= IDLE;
                    end
                end
                RBURST: begin
                    addr_cnt   <= addr_cnt + ADDR_W'(1);
                    beats_left <= beats_left - BC_W'(1);
                    if (beats_left == BC_W'(1)) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
